edc_crc_check: RTL

- Upstream companion to the 17-stage 16-bit delay line in the EDC path.
- Watches the same 16-bit word stream that feeds the delay line and computes a word-parallel CRC-16 over each fixed-length frame.
- Compares the result with the frame's trailing CRC word.
- Emits a pass/fail verdict delayed so it appears in the same cycle the CRC word exits the delay line.

---
 rtl/edc_pkg.sv | 26 ++
 rtl/edc_flag_delay.sv | 30 +++
 rtl/edc_crc_check.sv | 117 +++++++++++
 3 files changed

// File: rtl/edc_pkg.sv
// Shared constants, FSM state type and the word-parallel CRC-16 step for the EDC CRC checker.
package edc_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CHECK
   } state_e;

   // Folds one 16-bit word into the CRC: remainder of ((crc ^ word) * x^16) mod P,
   // i.e. 16 MSB-first serial shifts unrolled into a single combinational step.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic [15:0] word,
                                              input logic [15:0] poly);
      logic [15:0] r;
      r = crc ^ word;
      for (int i = 0; i < 16; i++) begin
         r = r[15] ? ((r << 1) ^ poly) : (r << 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/edc_flag_delay.sv
// Fixed-depth register pipe with no enable; async active-low reset clears every stage.
module edc_flag_delay #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DEPTH];

   // Shift every clock so the pipe stays in lockstep with the data delay line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/edc_crc_check.sv
// Per-frame CRC-16 checker whose verdict is delayed to line up with the CRC word leaving
// the EDC delay line. FSM, word counter and CRC register live here; the verdict delay is
// a separate register pipe.
module edc_crc_check
   import edc_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = 8,
   parameter int unsigned ALIGN_LAT   = 17,
   parameter logic [15:0] CRC_POLY    = CRC16_POLY,
   parameter logic [15:0] CRC_INIT    = CRC16_INIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] d_in,
   input  logic        d_valid,
   input  logic        sof,
   output logic        frame_done,
   output logic        crc_err,
   output logic [15:0] crc_calc,
   output logic        abort
);

   localparam int unsigned CNT_W    = $clog2(FRAME_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS);
   localparam int unsigned VERDICT_W = 18;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [15:0]            crc_q, crc_d;
   logic                   abort_q, abort_d;
   logic                   push;
   logic                   err;
   logic [15:0]            step_first;
   logic [15:0]            step_next;
   logic [VERDICT_W-1:0]   verdict_in;
   logic [VERDICT_W-1:0]   verdict_out;

   assign step_first = crc16_step(CRC_INIT, d_in, CRC_POLY);
   assign step_next  = crc16_step(crc_q, d_in, CRC_POLY);

   // State, counter, CRC accumulator and the undelayed abort pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         crc_q   <= CRC_INIT;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         abort_q <= abort_d;
      end
   end

   // Next-state logic; a sof in DATA or CHECK restarts the frame on the same word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      abort_d = 1'b0;
      push    = 1'b0;
      err     = 1'b0;
      if (d_valid) begin
         if (sof) begin
            abort_d = (state_q != IDLE);
            crc_d   = step_first;
            cnt_d   = CNT_W'(1);
            state_d = (FRAME_WORDS == 1) ? CHECK : DATA;
         end else begin
            unique case (state_q)
               IDLE: begin
                  // Words outside a frame are ignored.
               end
               DATA: begin
                  crc_d = step_next;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_d == LAST_CNT) begin
                     state_d = CHECK;
                  end
               end
               CHECK: begin
                  push    = 1'b1;
                  err     = (d_in != crc_q);
                  crc_d   = CRC_INIT;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  crc_d   = CRC_INIT;
               end
            endcase
         end
      end
   end

   // Non-verdict slots stay all-zero so no stale crc_calc/crc_err leaks out.
   assign verdict_in = push ? {1'b1, err, crc_q} : '0;

   edc_flag_delay #(
      .WIDTH (VERDICT_W),
      .DEPTH (ALIGN_LAT)
   ) u_flag_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (verdict_in),
      .dout  (verdict_out)
   );

   assign frame_done = verdict_out[17];
   assign crc_err    = verdict_out[16];
   assign crc_calc   = verdict_out[15:0];
   assign abort      = abort_q;

endmodule
